chamber_pressure: RTL and testbench

Airlock chamber pressure model and status generator, directly downstream of the evacuation controller. It consumes the Evacuation command and a Pressurization command. It steps a chamber pressure counter down or up at a fixed rate while both doors are closed. It produces the Evacuated/Pressurized status flags that the controllers use to end their sequences, and latches a sticky Fault on interlock violations.

---
 rtl/airlock_pkg.sv | 16 +
 rtl/chamber_pressure_step_timer.sv | 30 +++
 rtl/chamber_pressure.sv | 120 ++++++++++++
 tb/tb_chamber_pressure.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/airlock_pkg.sv
// Shared airlock state encodings used by the chamber model and the
// evacuation/pressurization controllers.
package airlock_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      PRESSURIZED  = 3'd0,
      EVACUATING   = 3'd1,
      EVACUATED    = 3'd2,
      PRESSURIZING = 3'd3,
      PARTIAL      = 3'd4,
      FAULT        = 3'd5
   } airlock_state_t;

endpackage

// File: rtl/chamber_pressure_step_timer.sv
// Step divider: counts enabled cycles and pulses tick on the cycle that wraps,
// so one pressure unit changes every STEP_CYCLES enabled cycles.
module step_timer #(
   parameter int STEP_CYCLES = 2
) (
   input  logic Clock,
   input  logic Reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int DIV_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_CYCLES - 1);

   logic [DIV_W-1:0] r_div;

   assign tick = enable && (r_div == DIV_LAST);

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_div <= '0;
      end else if (clear || tick) begin
         r_div <= '0;
      end else if (enable) begin
         r_div <= r_div + DIV_W'(1);
      end
   end

endmodule

// File: rtl/chamber_pressure.sv
// Airlock chamber pressure model: steps pressure down/up while doors are
// closed, decodes Evacuated/Pressurized status and latches a sticky Fault.
//
// state        | meaning
// PRESSURIZED  | at full atmosphere, idle
// EVACUATING   | pumping down, one unit per step
// EVACUATED    | at vacuum, idle
// PRESSURIZING | filling, one unit per step
// PARTIAL      | between vacuum and atmosphere, holding
// FAULT        | interlock violation, frozen until Reset
module chamber_pressure
   import airlock_pkg::*;
#(
   parameter int PW          = 4,
   parameter int P_MAX       = 7,
   parameter int STEP_CYCLES = 2
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Evacuation,
   input  logic               Pressurization,
   input  logic               InnerClosed,
   input  logic               OuterClosed,
   output logic [PW-1:0]      Pressure,
   output logic               Evacuated,
   output logic               Pressurized,
   output logic               Fault,
   output logic [STATE_W-1:0] State
);

   localparam logic [PW-1:0] P_FULL = PW'(P_MAX);
   localparam logic [PW-1:0] P_ONE  = PW'(1);

   airlock_state_t r_state;
   airlock_state_t w_next;
   logic [PW-1:0]  r_pressure;
   logic           w_doors;
   logic           w_both;
   logic           w_evac_run;
   logic           w_press_run;
   logic           w_step_en;
   logic           w_tick;
   logic           w_clear;

   assign w_doors = InnerClosed && OuterClosed;
   assign w_both  = Evacuation && Pressurization;

   // Stepping is only allowed when the state will not be left for a
   // non-step reason, and never past the pressure limits.
   assign w_evac_run  = (r_state == EVACUATING) && w_doors && !w_both &&
                        Evacuation && (r_pressure != '0);
   assign w_press_run = (r_state == PRESSURIZING) && w_doors && !w_both &&
                        Pressurization && (r_pressure != P_FULL);
   assign w_step_en   = w_evac_run || w_press_run;

   step_timer #(
      .STEP_CYCLES (STEP_CYCLES)
   ) u_step_timer (
      .Clock  (Clock),
      .Reset  (Reset),
      .clear  (w_clear),
      .enable (w_step_en),
      .tick   (w_tick)
   );

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state    <= PRESSURIZED;
         r_pressure <= P_FULL;
      end else begin
         r_state <= w_next;
         if (w_tick && w_evac_run) begin
            r_pressure <= r_pressure - P_ONE;
         end else if (w_tick && w_press_run) begin
            r_pressure <= r_pressure + P_ONE;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         PRESSURIZED: begin
            if (w_both)                      w_next = FAULT;
            else if (Evacuation && w_doors)  w_next = EVACUATING;
         end
         EVACUATING: begin
            if (w_both || !w_doors)                   w_next = FAULT;
            else if (!Evacuation)                     w_next = PARTIAL;
            else if (w_tick && r_pressure == P_ONE)   w_next = EVACUATED;
         end
         EVACUATED: begin
            if (w_both || !w_doors)    w_next = FAULT;
            else if (Pressurization)   w_next = PRESSURIZING;
         end
         PRESSURIZING: begin
            if (w_both || !w_doors)                            w_next = FAULT;
            else if (!Pressurization)                          w_next = PARTIAL;
            else if (w_tick && r_pressure == P_FULL - P_ONE)   w_next = PRESSURIZED;
         end
         PARTIAL: begin
            if (w_both || !w_doors)    w_next = FAULT;
            else if (Evacuation)       w_next = EVACUATING;
            else if (Pressurization)   w_next = PRESSURIZING;
         end
         FAULT:   w_next = FAULT;
         default: w_next = FAULT;
      endcase
   end

   // Any state change discards partial progress toward the next step.
   assign w_clear = (w_next != r_state);

   assign Pressure    = r_pressure;
   assign State       = r_state;
   assign Evacuated   = (r_state == EVACUATED);
   assign Pressurized = (r_state == PRESSURIZED);
   assign Fault       = (r_state == FAULT);

endmodule

// File: tb/tb_chamber_pressure.sv
// Directed bench for chamber_pressure: stimulus queues hand-computed
// expectations tagged with an edge number; a monitor checks them at negedge.
module tb_chamber_pressure;
   import airlock_pkg::*;

   localparam int PW = 4;

   logic               Clock = 1'b0;
   logic               Reset;
   logic               Evacuation;
   logic               Pressurization;
   logic               InnerClosed;
   logic               OuterClosed;
   logic [PW-1:0]      Pressure;
   logic               Evacuated;
   logic               Pressurized;
   logic               Fault;
   logic [STATE_W-1:0] State;

   typedef struct {
      int             cyc;
      logic [PW-1:0]  p;
      airlock_state_t s;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   edge_cnt = 0;
   int   n_vec    = 0;
   int   n_bad    = 0;

   chamber_pressure #(
      .PW          (PW),
      .P_MAX       (7),
      .STEP_CYCLES (2)
   ) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .Evacuation     (Evacuation),
      .Pressurization (Pressurization),
      .InnerClosed    (InnerClosed),
      .OuterClosed    (OuterClosed),
      .Pressure       (Pressure),
      .Evacuated      (Evacuated),
      .Pressurized    (Pressurized),
      .Fault          (Fault),
      .State          (State)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) edge_cnt++;

   // Monitor: compare every expectation whose edge has just been taken.
   always @(negedge Clock) begin
      while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
         m_e = q.pop_front();
         n_vec++;
         if (m_e.cyc < edge_cnt) begin
            n_bad++;
            $display("FAIL missed_sample edge=%0d now=%0d", m_e.cyc, edge_cnt);
         end else if (Pressure !== m_e.p || State !== m_e.s ||
                      Evacuated !== (m_e.s == EVACUATED) ||
                      Pressurized !== (m_e.s == PRESSURIZED) ||
                      Fault !== (m_e.s == FAULT)) begin
            n_bad++;
            $display("FAIL edge%0d got P=%0d st=%0d ev=%b pr=%b f=%b want P=%0d st=%0d",
                     edge_cnt, Pressure, State, Evacuated, Pressurized, Fault,
                     m_e.p, m_e.s);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   // Expect state/pressure after the edge that is 'off' edges from now.
   task automatic expect_at(input int off, input int p, input airlock_state_t s);
      exp_t e;
      e.cyc = edge_cnt + off;
      e.p   = PW'(p);
      e.s   = s;
      q.push_back(e);
   endtask

   initial begin
      Reset = 1'b0; Evacuation = 1'b0; Pressurization = 1'b0;
      InnerClosed = 1'b1; OuterClosed = 1'b1;
      cyc(2);
      expect_at(0, 7, PRESSURIZED);
      Reset = 1'b1;
      cyc(3);
      expect_at(0, 7, PRESSURIZED);

      // Full pump-down: accept at k, 6 at k+2, 0 and EVACUATED at k+14.
      Evacuation = 1'b1;
      expect_at(1, 7, EVACUATING);
      expect_at(2, 7, EVACUATING);
      expect_at(3, 6, EVACUATING);
      expect_at(14, 1, EVACUATING);
      expect_at(15, 0, EVACUATED);
      cyc(15);
      cyc(3);
      expect_at(0, 0, EVACUATED);

      // Full fill from vacuum.
      Evacuation = 1'b0; Pressurization = 1'b1;
      expect_at(1, 0, PRESSURIZING);
      expect_at(3, 1, PRESSURIZING);
      expect_at(14, 6, PRESSURIZING);
      expect_at(15, 7, PRESSURIZED);
      cyc(15);
      Pressurization = 1'b0;
      cyc(1);

      // Drop Evacuation at pressure 4 -> PARTIAL, then resume.
      Evacuation = 1'b1;
      expect_at(7, 4, EVACUATING);
      cyc(7);
      Evacuation = 1'b0;
      expect_at(1, 4, PARTIAL);
      cyc(3);
      expect_at(0, 4, PARTIAL);
      Evacuation = 1'b1;
      expect_at(1, 4, EVACUATING);
      expect_at(8, 1, EVACUATING);
      expect_at(9, 0, EVACUATED);
      cyc(9);

      // Fill to 3, hold, re-evacuate, then open the outer door.
      Evacuation = 1'b0; Pressurization = 1'b1;
      expect_at(7, 3, PRESSURIZING);
      cyc(7);
      Pressurization = 1'b0;
      expect_at(1, 3, PARTIAL);
      cyc(1);
      Evacuation = 1'b1;
      expect_at(1, 3, EVACUATING);
      cyc(2);
      OuterClosed = 1'b0;
      expect_at(1, 3, FAULT);
      cyc(1);
      Evacuation = 1'b0; Pressurization = 1'b1; OuterClosed = 1'b1;
      cyc(4);
      expect_at(0, 3, FAULT);
      Reset = 1'b0;
      expect_at(1, 7, PRESSURIZED);
      cyc(1);
      Reset = 1'b1; Pressurization = 1'b0;
      cyc(2);
      expect_at(0, 7, PRESSURIZED);

      // Interlock: Evacuation with inner door open is ignored, not a fault.
      Evacuation = 1'b1; InnerClosed = 1'b0;
      expect_at(1, 7, PRESSURIZED);
      cyc(3);
      expect_at(0, 7, PRESSURIZED);
      // Both commands together always fault.
      Pressurization = 1'b1;
      expect_at(1, 7, FAULT);
      cyc(2);
      Reset = 1'b0; Evacuation = 1'b0; Pressurization = 1'b0; InnerClosed = 1'b1;
      expect_at(1, 7, PRESSURIZED);
      cyc(1);
      Reset = 1'b1;

      // Reset mid-fill at pressure 2 with a step half done.
      Evacuation = 1'b1;
      expect_at(15, 0, EVACUATED);
      cyc(15);
      Evacuation = 1'b0; Pressurization = 1'b1;
      expect_at(5, 2, PRESSURIZING);
      cyc(5);
      cyc(1);
      Reset = 1'b0;
      expect_at(1, 7, PRESSURIZED);
      cyc(1);
      Reset = 1'b1; Pressurization = 1'b0; Evacuation = 1'b1;
      expect_at(1, 7, EVACUATING);
      expect_at(2, 7, EVACUATING);
      expect_at(3, 6, EVACUATING);
      cyc(3);
      Evacuation = 1'b0;
      expect_at(1, 6, PARTIAL);
      cyc(3);

      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL unchecked_expectations left=%0d", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout edge=%0d", edge_cnt);
      $fatal(1, "timeout");
   end

endmodule
